// File: rtl/tcm_port_arbiter.sv
// Single-port TCM arbiter: shares one 32-bit RAM between the fetch and data ports with
// data priority, a fetch starvation limit, address range checks and one-cycle responses.

package tcm_port_arbiter_pkg;
  localparam int unsigned TAG_W = 11;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_e;

  typedef struct packed {
    logic             vld;
    logic             port_d;
    logic             err;
    logic             is_wr;
    logic [TAG_W-1:0] tag;
  } resp_t;
endpackage

module tcm_port_arbiter
  import tcm_port_arbiter_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int unsigned MEM_AW     = 14,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              mem_i_rd_i,
  input  logic [31:0]       mem_i_pc_i,
  output logic              mem_i_accept_o,
  output logic              mem_i_valid_o,
  output logic              mem_i_error_o,
  output logic [31:0]       mem_i_inst_o,

  input  logic              mem_d_rd_i,
  input  logic [3:0]        mem_d_wr_i,
  input  logic [31:0]       mem_d_addr_i,
  input  logic [31:0]       mem_d_data_wr_i,
  input  logic [TAG_W-1:0]  mem_d_req_tag_i,
  output logic              mem_d_accept_o,
  output logic              mem_d_ack_o,
  output logic              mem_d_error_o,
  output logic [TAG_W-1:0]  mem_d_resp_tag_o,
  output logic [31:0]       mem_d_data_rd_o,

  output logic              ram_en_o,
  output logic [3:0]        ram_wr_o,
  output logic [MEM_AW-1:0] ram_addr_o,
  output logic [31:0]       ram_data_o,
  input  logic [31:0]       ram_data_i
);

  localparam int unsigned     HI_LSB     = MEM_AW + 2;
  localparam int unsigned     CNT_W      = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_nxt;
  resp_t            resp_q;
  resp_t            resp_nxt;
  gnt_e             gnt;

  logic d_req;
  logic i_req;
  logic d_is_wr;
  logic d_in_range;
  logic i_in_range;
  logic live_i;
  logic live_d;
  logic unused_addr_lsb;

  assign d_is_wr         = |mem_d_wr_i;
  assign d_req           = mem_d_rd_i | d_is_wr;
  assign i_req           = mem_i_rd_i;
  assign d_in_range      = (mem_d_addr_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]);
  assign i_in_range      = (mem_i_pc_i[31:HI_LSB] == BASE_ADDR[31:HI_LSB]) &&
                           (mem_i_pc_i[1:0] == 2'b00);
  assign unused_addr_lsb = ^mem_d_addr_i[1:0];

  // Data wins until the pending fetch has lost STARVE_MAX times in a row.
  always_comb begin
    gnt = GNT_NONE;
    if (!rst_i) begin
      if (d_req && (starve_cnt < STARVE_LIM)) begin
        gnt = GNT_D;
      end else if (i_req) begin
        gnt = GNT_I;
      end else if (d_req) begin
        gnt = GNT_D;
      end
    end
  end

  always_comb begin
    starve_cnt_nxt = starve_cnt;
    if (!i_req || (gnt == GNT_I)) begin
      starve_cnt_nxt = '0;
    end else if ((gnt == GNT_D) && (starve_cnt < STARVE_LIM)) begin
      starve_cnt_nxt = starve_cnt + CNT_W'(1);
    end
  end

  // RAM drive: out-of-range or misaligned grants never touch the macro.
  always_comb begin
    mem_i_accept_o = (gnt == GNT_I);
    mem_d_accept_o = (gnt == GNT_D);
    ram_en_o       = 1'b0;
    ram_wr_o       = 4'b0000;
    ram_addr_o     = '0;
    ram_data_o     = '0;
    if ((gnt == GNT_I) && i_in_range) begin
      ram_en_o   = 1'b1;
      ram_addr_o = mem_i_pc_i[MEM_AW+1:2];
    end else if ((gnt == GNT_D) && d_in_range) begin
      ram_en_o   = 1'b1;
      ram_addr_o = mem_d_addr_i[MEM_AW+1:2];
      if (d_is_wr) begin
        ram_wr_o   = mem_d_wr_i;
        ram_data_o = mem_d_data_wr_i;
      end
    end
  end

  always_comb begin
    resp_nxt = '0;
    if (gnt == GNT_D) begin
      resp_nxt.vld    = 1'b1;
      resp_nxt.port_d = 1'b1;
      resp_nxt.err    = ~d_in_range;
      resp_nxt.is_wr  = d_is_wr;
      resp_nxt.tag    = mem_d_req_tag_i;
    end else if (gnt == GNT_I) begin
      resp_nxt.vld    = 1'b1;
      resp_nxt.err    = ~i_in_range;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_q     <= '0;
      starve_cnt <= '0;
    end else begin
      resp_q     <= resp_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  // A response pending across a reset edge is discarded, so outputs are gated by rst_i.
  assign live_i = resp_q.vld & ~resp_q.port_d & ~rst_i;
  assign live_d = resp_q.vld &  resp_q.port_d & ~rst_i;

  always_comb begin
    mem_i_valid_o    = live_i;
    mem_i_error_o    = live_i & resp_q.err;
    mem_i_inst_o     = (live_i && !resp_q.err) ? ram_data_i : 32'h0;
    mem_d_ack_o      = live_d;
    mem_d_error_o    = live_d & resp_q.err;
    mem_d_resp_tag_o = live_d ? resp_q.tag : '0;
    mem_d_data_rd_o  = (live_d && !resp_q.err && !resp_q.is_wr) ? ram_data_i : 32'h0;
  end

endmodule

// File: tb/tb_tcm_port_arbiter.sv
// Bench for tcm_port_arbiter: RAM model, vector table, directed corner sequences and
// randomized traffic checked against a rule-level reference model.

module tb_tcm_port_arbiter;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int unsigned AW    = 14;
  localparam int unsigned SMAX  = 4;
  localparam int unsigned WORDS = 1 << AW;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          mem_i_rd_i = 1'b0;
  logic [31:0]   mem_i_pc_i = '0;
  logic          mem_i_accept_o, mem_i_valid_o, mem_i_error_o;
  logic [31:0]   mem_i_inst_o;
  logic          mem_d_rd_i = 1'b0;
  logic [3:0]    mem_d_wr_i = '0;
  logic [31:0]   mem_d_addr_i = '0;
  logic [31:0]   mem_d_data_wr_i = '0;
  logic [10:0]   mem_d_req_tag_i = '0;
  logic          mem_d_accept_o, mem_d_ack_o, mem_d_error_o;
  logic [10:0]   mem_d_resp_tag_o;
  logic [31:0]   mem_d_data_rd_o;
  logic          ram_en_o;
  logic [3:0]    ram_wr_o;
  logic [AW-1:0] ram_addr_o;
  logic [31:0]   ram_data_o;
  logic [31:0]   ram_data_i;

  always #5 clk_i = ~clk_i;

  tcm_port_arbiter #(.BASE_ADDR(BASE), .MEM_AW(AW), .STARVE_MAX(SMAX)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_i_rd_i(mem_i_rd_i), .mem_i_pc_i(mem_i_pc_i), .mem_i_accept_o(mem_i_accept_o),
    .mem_i_valid_o(mem_i_valid_o), .mem_i_error_o(mem_i_error_o), .mem_i_inst_o(mem_i_inst_o),
    .mem_d_rd_i(mem_d_rd_i), .mem_d_wr_i(mem_d_wr_i), .mem_d_addr_i(mem_d_addr_i),
    .mem_d_data_wr_i(mem_d_data_wr_i), .mem_d_req_tag_i(mem_d_req_tag_i),
    .mem_d_accept_o(mem_d_accept_o), .mem_d_ack_o(mem_d_ack_o), .mem_d_error_o(mem_d_error_o),
    .mem_d_resp_tag_o(mem_d_resp_tag_o), .mem_d_data_rd_o(mem_d_data_rd_o),
    .ram_en_o(ram_en_o), .ram_wr_o(ram_wr_o), .ram_addr_o(ram_addr_o),
    .ram_data_o(ram_data_o), .ram_data_i(ram_data_i)
  );

  // Synchronous RAM macro with a backdoor load port.
  logic [31:0]   ram [WORDS];
  logic [31:0]   ram_q = '0;
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [31:0]   bd_data = '0;

  always @(posedge clk_i) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (ram_en_o) begin
      if (ram_wr_o == 4'b0000) ram_q <= ram[ram_addr_o];
      else for (int b = 0; b < 4; b++)
        if (ram_wr_o[b]) ram[ram_addr_o][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end
  assign ram_data_i = ram_q;

  // Reference model state: memory image, consecutive fetch losses, expected response.
  logic [31:0] mdl [WORDS];
  int          losses = 0;
  bit          ev_i = 0, ev_d = 0, e_err = 0;
  logic [31:0] e_data = '0;
  logic [10:0] e_tag = '0;

  bit          s_i_acc, s_d_acc, s_en, s_i_vld, s_d_ack, s_i_err, s_d_err;
  logic [31:0] s_i_inst, s_d_data, s_ram_data;
  logic [10:0] s_d_tag;
  logic [3:0]  s_wr;
  logic [AW-1:0] s_addr;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    return (a - BASE) < 32'(WORDS * 4);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic drive(input logic ird, input logic [31:0] ipc, input logic drd,
                       input logic [3:0] dwr, input logic [31:0] daddr,
                       input logic [31:0] dwd, input logic [10:0] dtag);
    mem_i_rd_i = ird; mem_i_pc_i = ipc; mem_d_rd_i = drd; mem_d_wr_i = dwr;
    mem_d_addr_i = daddr; mem_d_data_wr_i = dwd; mem_d_req_tag_i = dtag;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0);
  endtask

  task automatic preload(input int w, input logic [31:0] d);
    bd_we = 1'b1; bd_addr = AW'(w); bd_data = d; mdl[w] = d;
    @(posedge clk_i); #1;
    bd_we = 1'b0;
  endtask

  // One clock: check DUT against the model at the falling edge, then advance the model.
  task automatic step();
    bit dreq, ireq, gi, gd, dok, iok, xen;
    int w;
    @(negedge clk_i);
    dreq = mem_d_rd_i || (mem_d_wr_i != 4'h0);
    ireq = mem_i_rd_i;
    gi = 0; gd = 0;
    if (!rst_i) begin
      gi = ireq && (!dreq || losses >= int'(SMAX));
      gd = dreq && !gi;
    end
    dok = in_rng(mem_d_addr_i);
    iok = in_rng(mem_i_pc_i) && (mem_i_pc_i[1:0] == 2'b00);
    if (rst_i) begin ev_i = 0; ev_d = 0; end

    chk1("i_valid", mem_i_valid_o, ev_i);
    chk1("i_error", mem_i_error_o, ev_i && e_err);
    chk32("i_inst", mem_i_inst_o, ev_i ? e_data : 32'h0);
    chk1("d_ack", mem_d_ack_o, ev_d);
    chk1("d_error", mem_d_error_o, ev_d && e_err);
    chk32("d_tag", 32'(mem_d_resp_tag_o), ev_d ? 32'(e_tag) : 32'h0);
    chk32("d_data", mem_d_data_rd_o, ev_d ? e_data : 32'h0);
    chk1("i_accept", mem_i_accept_o, gi);
    chk1("d_accept", mem_d_accept_o, gd);
    xen = (gi && iok) || (gd && dok);
    chk1("ram_en", ram_en_o, xen);
    chk32("ram_wr", 32'(ram_wr_o), (gd && dok) ? 32'(mem_d_wr_i) : 32'h0);
    if (xen) chk32("ram_addr", 32'(ram_addr_o), gi ? 32'(widx(mem_i_pc_i)) : 32'(widx(mem_d_addr_i)));
    if (gd && dok && mem_d_wr_i != 4'h0) chk32("ram_wdata", ram_data_o, mem_d_data_wr_i);

    s_i_acc = mem_i_accept_o; s_d_acc = mem_d_accept_o; s_en = ram_en_o;
    s_i_vld = mem_i_valid_o; s_d_ack = mem_d_ack_o;
    s_i_err = mem_i_error_o; s_d_err = mem_d_error_o;
    s_i_inst = mem_i_inst_o; s_d_data = mem_d_data_rd_o; s_d_tag = mem_d_resp_tag_o;
    s_wr = ram_wr_o; s_addr = ram_addr_o; s_ram_data = ram_data_o;

    ev_i = gi; ev_d = gd; e_err = 0; e_data = 32'h0; e_tag = 11'h0;
    if (gd) begin
      e_err = !dok;
      e_tag = mem_d_req_tag_i;
      if (dok) begin
        w = widx(mem_d_addr_i);
        if (mem_d_wr_i == 4'h0) e_data = mdl[w];
        else for (int b = 0; b < 4; b++)
          if (mem_d_wr_i[b]) mdl[w][8*b +: 8] = mem_d_data_wr_i[8*b +: 8];
      end
    end else if (gi) begin
      e_err = !iok;
      if (iok) e_data = mdl[widx(mem_i_pc_i)];
    end
    losses = (!rst_i && ireq && gd) ? losses + 1 : 0;
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic        ird;
    logic [31:0] pc;
    logic        drd;
    logic [3:0]  dwr;
    logic [31:0] addr;
    logic        x_i_acc;
    logic        x_d_acc;
    logic        x_en;
    logic        x_err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b1, 1'b0};
    tbl[1] = '{1'b1, 32'h8000_0002, 1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 32'h0000_0000, 1'b0, 4'h0, 32'h0,          1'b1, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h0000_1000,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h8000_FFFC,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h8001_0000,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 32'h0,         1'b0, 4'hF, 32'h9000_0000,  1'b0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 32'h0,         1'b1, 4'h0, 32'h8000_0011,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[8] = '{1'b1, 32'h8000_0004, 1'b1, 4'h0, 32'h8000_0008,  1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 32'h0,         1'b1, 4'hF, 32'h8000_0020,  1'b0, 1'b1, 1'b1, 1'b0};

    for (int w = 0; w < 64; w++) preload(w, $urandom);
    preload(0, 32'h0010_0093);
    preload(1, 32'h0010_8113);
    preload(4, 32'h1122_3344);
    preload(WORDS - 1, 32'hCAFE_F00D);

    // Reset held with both ports requesting.
    drive(1'b1, BASE, 1'b1, 4'h0, BASE + 32'h8, 32'h0, 11'h7);
    for (int k = 0; k < 3; k++) begin
      step();
      chk1("rst_i_acc", s_i_acc, 1'b0);
      chk1("rst_d_acc", s_d_acc, 1'b0);
      chk32("rst_ram_addr", 32'(s_addr), 32'h0);
      chk32("rst_ram_wdata", s_ram_data, 32'h0);
    end
    rst_i = 1'b0;
    step();
    chk1("first_d_accept", s_d_acc, 1'b1);
    chk1("first_i_accept", s_i_acc, 1'b0);
    idle(); step(); step();

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ird, tbl[i].pc, tbl[i].drd, tbl[i].dwr, tbl[i].addr, 32'h5A5A_0000 + 32'(i), 11'(i));
      step();
      chk1($sformatf("tbl%0d_i_acc", i), s_i_acc, tbl[i].x_i_acc);
      chk1($sformatf("tbl%0d_d_acc", i), s_d_acc, tbl[i].x_d_acc);
      chk1($sformatf("tbl%0d_en", i), s_en, tbl[i].x_en);
      idle();
      step();
      chk1($sformatf("tbl%0d_err", i), s_i_err | s_d_err, tbl[i].x_err);
    end

    // Back-to-back fetch stream.
    drive(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0); step();
    drive(1'b1, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0); step();
    chk1("fetch0_valid", s_i_vld, 1'b1);
    chk32("fetch0_inst", s_i_inst, 32'h0010_0093);
    idle(); step();
    chk1("fetch1_valid", s_i_vld, 1'b1);
    chk1("fetch1_error", s_i_err, 1'b0);
    chk32("fetch1_inst", s_i_inst, 32'h0010_8113);

    // Partial write then read of the same word.
    drive(1'b0, 32'h0, 1'b0, 4'b0011, 32'h8000_0010, 32'hAABB_CCDD, 11'h2A5); step();
    drive(1'b0, 32'h0, 1'b1, 4'b0000, 32'h8000_0010, 32'h0, 11'h155); step();
    chk1("wr_ack", s_d_ack, 1'b1);
    chk32("wr_tag", 32'(s_d_tag), 32'h2A5);
    chk32("wr_data", s_d_data, 32'h0);
    idle(); step();
    chk1("rd_ack", s_d_ack, 1'b1);
    chk32("rd_tag", 32'(s_d_tag), 32'h155);
    chk32("rd_data", s_d_data, 32'h1122_CCDD);

    // Continuous contention.
    drive(1'b1, 32'h8000_0020, 1'b1, 4'h0, 32'h8000_0040, 32'h0, 11'h3);
    for (int k = 0; k < 20; k++) begin
      step();
      chk1($sformatf("starve%0d_i", k), s_i_acc, (k % 5) == 4);
      chk1($sformatf("starve%0d_d", k), s_d_acc, (k % 5) != 4);
    end
    idle(); step();

    // Reset in the cycle after a fetch grant.
    drive(1'b1, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 32'h0, 11'h0); step();
    chk1("mid_accept", s_i_acc, 1'b1);
    idle(); rst_i = 1'b1; step();
    chk1("mid_rst_valid", s_i_vld, 1'b0);
    chk32("mid_rst_inst", s_i_inst, 32'h0);
    rst_i = 1'b0; step();

    // Randomized traffic.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] pc, da;
      logic [3:0]  wr;
      pc = BASE + 32'($urandom_range(0, 63) * 4);
      if ($urandom_range(0, 9) == 0) pc = pc + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      da = BASE + 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) da = $urandom;
      wr = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      rst_i = ($urandom_range(0, 59) == 0);
      drive(1'($urandom), pc, 1'($urandom), wr, da, $urandom, 11'($urandom));
      step();
    end
    rst_i = 1'b0;
    idle(); step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
